// File: rtl/axi_trace_capture.sv
// Passive AXI AW/AR tracer: timestamps each handshaked address beat into a circular
// record buffer that drains over a valid/ready stream, counting records lost to overflow.
package axi_trace_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } axi_ax_t;

    typedef struct packed {
        axi_ax_t     aw;
        logic        aw_valid;
        logic [63:0] w_data;
        logic        w_valid;
        logic        b_ready;
        axi_ax_t     ar;
        logic        ar_valid;
        logic        r_ready;
    } axi_req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        logic r_valid;
    } axi_resp_t;
endpackage

module axi_trace_capture #(
    parameter int unsigned Depth     = 16,
    parameter int unsigned TsWidth   = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter type axi_req_t  = axi_trace_pkg::axi_req_t,
    parameter type axi_resp_t = axi_trace_pkg::axi_resp_t,
    localparam int unsigned RecWidth  = 1 + IdWidth + AddrWidth + 8 + 3 + 2 + TsWidth,
    localparam int unsigned FillWidth = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  axi_req_t             axi_req_i,
    input  axi_resp_t            axi_resp_i,
    output logic                 trace_valid_o,
    input  logic                 trace_ready_i,
    output logic [RecWidth-1:0]  trace_o,
    output logic [FillWidth-1:0] fill_o,
    output logic [15:0]          drop_cnt_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam logic [FillWidth-1:0] Full       = FillWidth'(Depth);
    localparam logic [FillWidth-1:0] AlmostFull = FillWidth'(Depth - 1);

    logic [RecWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q, ar_slot;
    logic [FillWidth-1:0] fill_q;
    logic [TsWidth-1:0]   ts_q;
    logic [15:0]          drop_q;
    logic                 aw_hs, ar_hs, push_aw, push_ar, pop;
    logic [1:0]           n_push, n_drop;
    logic [16:0]          drop_sum;
    logic [RecWidth-1:0]  aw_rec, ar_rec;
    logic                 unused_bus;

    // Only address-channel fields are recorded; the rest of the bus is snooped for nothing.
    assign unused_bus = ^{axi_req_i, axi_resp_i};

    assign aw_hs = enable_i & axi_req_i.aw_valid & axi_resp_i.aw_ready;
    assign ar_hs = enable_i & axi_req_i.ar_valid & axi_resp_i.ar_ready;

    assign aw_rec = {1'b0, IdWidth'(axi_req_i.aw.id), AddrWidth'(axi_req_i.aw.addr),
                     axi_req_i.aw.len, axi_req_i.aw.size, axi_req_i.aw.burst, ts_q};
    assign ar_rec = {1'b1, IdWidth'(axi_req_i.ar.id), AddrWidth'(axi_req_i.ar.addr),
                     axi_req_i.ar.len, axi_req_i.ar.size, axi_req_i.ar.burst, ts_q};

    // Space is judged on the fill at cycle start; a pop in the same cycle frees nothing.
    always_comb begin
        push_aw  = aw_hs && (fill_q != Full);
        push_ar  = ar_hs && ((fill_q < AlmostFull) || ((fill_q == AlmostFull) && !aw_hs));
        n_push   = {1'b0, push_aw} + {1'b0, push_ar};
        n_drop   = {1'b0, aw_hs & ~push_aw} + {1'b0, ar_hs & ~push_ar};
        ar_slot  = wr_ptr_q + PtrWidth'(push_aw);
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        pop      = (fill_q != '0) && trace_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ts_q     <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PtrWidth'(n_push);
            rd_ptr_q <= rd_ptr_q + PtrWidth'(pop);
            fill_q   <= fill_q + FillWidth'(n_push) - FillWidth'(pop);
            ts_q     <= ts_q + TsWidth'(1);
            drop_q   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_aw) mem_q[wr_ptr_q] <= aw_rec;
        if (push_ar) mem_q[ar_slot]  <= ar_rec;
    end

    // Storage is not reset, so the head is masked to keep trace_o at zero when empty.
    assign trace_valid_o = (fill_q != '0);
    assign trace_o       = trace_valid_o ? mem_q[rd_ptr_q] : '0;
    assign fill_o        = fill_q;
    assign drop_cnt_o    = drop_q;
endmodule
